// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate datapath memories (input and output tile stores).
// Holds the tile geometry, the fill-state encoding and the big-endian byte-lane mapping.
// Both memories use the same lane helper, so their packing always matches.
package rotate_pkg;

  localparam int MEM_WORDS      = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int MEM_BYTES      = MEM_WORDS * BYTES_PER_WORD;

  // Byte lane within a 32-bit word; lane 0 is the most significant byte
  localparam logic [1:0] LANE_0 = 2'd0;  // bits [31:24] -> byte 4k
  localparam logic [1:0] LANE_1 = 2'd1;  // bits [23:16] -> byte 4k+1
  localparam logic [1:0] LANE_2 = 2'd2;  // bits [15:8]  -> byte 4k+2
  localparam logic [1:0] LANE_3 = 2'd3;  // bits [7:0]   -> byte 4k+3

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } imem_state_t;

  // Extract the byte that belongs at lane position 'lane' of a word
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      LANE_0:  b = w[31:24];
      LANE_1:  b = w[23:16];
      LANE_2:  b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/input_mem_bank.sv
// 64x8 tile store: one 4-byte word write port, three registered byte read ports.
// Read latency 1 cycle; a read hitting the word being written returns the new byte.
// Never stalls; out-of-range addresses (addr[7:6] != 0) read as 8'h00.
module input_mem_bank
  import rotate_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [3:0]  i_widx,
  input  logic [31:0] i_wdata,
  input  logic [7:0]  i_addr_b,
  input  logic [7:0]  i_addr_g,
  input  logic [7:0]  i_addr_r,
  output logic [7:0]  o_pix_b,
  output logic [7:0]  o_pix_g,
  output logic [7:0]  o_pix_r
);

  logic [7:0] r_mem [MEM_BYTES];
  logic [7:0] r_pix_b, r_pix_g, r_pix_r;
  logic [7:0] w_nxt_b, w_nxt_g, w_nxt_r;

  // Byte seen by a read port this cycle, with write-through for the word in flight
  function automatic logic [7:0] rd_byte(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h00;
    if (a[7:6] == 2'b00) begin
      if (i_we && (a[5:2] == i_widx)) b = lane_byte(i_wdata, a[1:0]);
      else                            b = r_mem[a[5:0]];
    end
    return b;
  endfunction

  // Next-cycle values of the three read ports
  always_comb begin
    w_nxt_b = rd_byte(i_addr_b);
    w_nxt_g = rd_byte(i_addr_g);
    w_nxt_r = rd_byte(i_addr_r);
  end

  // Store update: reset clears the whole tile, otherwise write four lanes of a word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_BYTES; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      for (int l = 0; l < BYTES_PER_WORD; l++)
        r_mem[{i_widx, 2'(l)}] <= lane_byte(i_wdata, 2'(l));
    end
  end

  // Registered pixel outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_b <= 8'h00;
      r_pix_g <= 8'h00;
      r_pix_r <= 8'h00;
    end else begin
      r_pix_b <= w_nxt_b;
      r_pix_g <= w_nxt_g;
      r_pix_r <= w_nxt_r;
    end
  end

  assign o_pix_b = r_pix_b;
  assign o_pix_g = r_pix_g;
  assign o_pix_r = r_pix_r;

endmodule

// File: rtl/input_mem.sv
// Pixel input buffer: unpacks bus read words into a 64-byte tile, serves 3 pixel reads.
// Pixel reads 1 cycle latency; status outputs update on the accepting edge.
// Never backpressures: words outside FILL are dropped and flagged in the sticky OVF bit.
module input_mem
  import rotate_pkg::*;
#(
  parameter int TILE_WORDS = MEM_WORDS
) (
  input  logic        I_IMEM_HCLK,
  input  logic        I_IMEM_HRESET,
  input  logic        I_IMEM_START,
  input  logic        I_IMEM_DONE,
  input  logic        I_IMEM_RDATA_VALID,
  input  logic [31:0] I_IMEM_RDATA,
  input  logic [7:0]  I_IMEM_PIXEL_ADDRB,
  input  logic [7:0]  I_IMEM_PIXEL_ADDRG,
  input  logic [7:0]  I_IMEM_PIXEL_ADDRR,
  output logic [7:0]  O_IMEM_PIXEL_B,
  output logic [7:0]  O_IMEM_PIXEL_G,
  output logic [7:0]  O_IMEM_PIXEL_R,
  output logic        O_IMEM_FULL,
  output logic        O_IMEM_BUSY,
  output logic [4:0]  O_IMEM_WORD_CNT,
  output logic        O_IMEM_OVF
);

  localparam logic [4:0] LAST_IDX = 5'(TILE_WORDS - 1);

  imem_state_t r_state;
  logic [4:0]  r_word_cnt;
  logic        r_full, r_busy, r_ovf;
  logic        w_we;
  logic [3:0]  w_widx;

  // A word is stored while filling, or at index 0 when it coincides with START
  assign w_we   = I_IMEM_RDATA_VALID && (I_IMEM_START || (r_state == ST_FILL));
  assign w_widx = I_IMEM_START ? 4'd0 : r_word_cnt[3:0];

  // Fill FSM with word counter, registered FULL/BUSY and sticky overflow flag
  always_ff @(posedge I_IMEM_HCLK) begin
    if (I_IMEM_HRESET) begin
      r_state    <= ST_EMPTY;
      r_word_cnt <= 5'd0;
      r_full     <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (I_IMEM_START) begin
      r_state    <= ST_FILL;
      r_word_cnt <= I_IMEM_RDATA_VALID ? 5'd1 : 5'd0;
      r_full     <= 1'b0;
      r_busy     <= 1'b1;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (I_IMEM_DONE) begin
            // Abort: any word in this cycle is still written by the bank
            r_state    <= ST_EMPTY;
            r_word_cnt <= 5'd0;
            r_busy     <= 1'b0;
          end else if (I_IMEM_RDATA_VALID) begin
            r_word_cnt <= r_word_cnt + 5'd1;
            if (r_word_cnt == LAST_IDX) begin
              r_state <= ST_FULL;
              r_full  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          if (I_IMEM_RDATA_VALID) r_ovf <= 1'b1;
          if (I_IMEM_DONE) begin
            r_state    <= ST_EMPTY;
            r_word_cnt <= 5'd0;
            r_full     <= 1'b0;
          end
        end
        default: begin
          if (I_IMEM_RDATA_VALID) r_ovf <= 1'b1;
        end
      endcase
    end
  end

  input_mem_bank u_bank (
    .i_clk    (I_IMEM_HCLK),
    .i_rst    (I_IMEM_HRESET),
    .i_we     (w_we),
    .i_widx   (w_widx),
    .i_wdata  (I_IMEM_RDATA),
    .i_addr_b (I_IMEM_PIXEL_ADDRB),
    .i_addr_g (I_IMEM_PIXEL_ADDRG),
    .i_addr_r (I_IMEM_PIXEL_ADDRR),
    .o_pix_b  (O_IMEM_PIXEL_B),
    .o_pix_g  (O_IMEM_PIXEL_G),
    .o_pix_r  (O_IMEM_PIXEL_R)
  );

  assign O_IMEM_FULL     = r_full;
  assign O_IMEM_BUSY     = r_busy;
  assign O_IMEM_WORD_CNT = r_word_cnt;
  assign O_IMEM_OVF      = r_ovf;

endmodule

// File: tb/tb_input_mem.sv
// Self-checking bench for input_mem: directed test-plan scenarios, then random traffic.
// Every cycle all outputs are compared against a behavioural tile model.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_input_mem;

  logic        clk = 1'b0;
  logic        rst, start, done, vld;
  logic [31:0] rdata;
  logic [7:0]  ab, ag, ar;
  logic [7:0]  pb, pg, pr;
  logic        full, busy, ovf;
  logic [4:0]  cnt;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model: tile contents plus loading status
  logic [7:0] m_mem [64];
  bit         m_loading, m_full, m_ovf;
  int         m_cnt;
  logic [7:0] e_b, e_g, e_r;

  always #5 clk = ~clk;

  input_mem dut (
    .I_IMEM_HCLK        (clk),
    .I_IMEM_HRESET      (rst),
    .I_IMEM_START       (start),
    .I_IMEM_DONE        (done),
    .I_IMEM_RDATA_VALID (vld),
    .I_IMEM_RDATA       (rdata),
    .I_IMEM_PIXEL_ADDRB (ab),
    .I_IMEM_PIXEL_ADDRG (ag),
    .I_IMEM_PIXEL_ADDRR (ar),
    .O_IMEM_PIXEL_B     (pb),
    .O_IMEM_PIXEL_G     (pg),
    .O_IMEM_PIXEL_R     (pr),
    .O_IMEM_FULL        (full),
    .O_IMEM_BUSY        (busy),
    .O_IMEM_WORD_CNT    (cnt),
    .O_IMEM_OVF         (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    return (a < 8'd64) ? m_mem[a[5:0]] : 8'h00;
  endfunction

  task automatic model_store(input int idx, input logic [31:0] w);
    for (int j = 0; j < 4; j++) m_mem[idx * 4 + j] = 8'(w >> (24 - 8 * j));
  endtask

  // Apply one clock edge's worth of the tile rules to the model
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
      m_loading = 0; m_full = 0; m_ovf = 0; m_cnt = 0;
      e_b = 8'h00; e_g = 8'h00; e_r = 8'h00;
      return;
    end
    if (start) begin
      m_loading = 1; m_full = 0; m_ovf = 0; m_cnt = 0;
      if (vld) begin model_store(0, rdata); m_cnt = 1; end
    end else if (m_loading) begin
      if (vld) begin model_store(m_cnt, rdata); m_cnt++; end
      if (done) begin
        m_loading = 0; m_cnt = 0;
      end else if (m_cnt == 16) begin
        m_loading = 0; m_full = 1;
      end
    end else begin
      if (vld) m_ovf = 1;
      if (done && m_full) begin m_full = 0; m_cnt = 0; end
    end
    // Memory already holds this cycle's word, so the bypass shows up naturally
    e_b = model_read(ab); e_g = model_read(ag); e_r = model_read(ar);
  endtask

  task automatic cycle(input bit i_rst, input bit i_start, input bit i_done, input bit i_vld,
                       input logic [31:0] i_dat, input logic [7:0] i_ab, input logic [7:0] i_ag,
                       input logic [7:0] i_ar);
    @(negedge clk);
    rst = i_rst; start = i_start; done = i_done; vld = i_vld; rdata = i_dat;
    ab = i_ab; ag = i_ag; ar = i_ar;
    @(posedge clk);
    model_step();
    #1;
    chk("pix_b", 32'(pb), 32'(e_b));
    chk("pix_g", 32'(pg), 32'(e_g));
    chk("pix_r", 32'(pr), 32'(e_r));
    chk("full", 32'(full), 32'(m_full));
    chk("busy", 32'(busy), 32'(m_loading));
    chk("word_cnt", 32'(cnt), 32'(m_cnt));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic word(input logic [31:0] d, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2);
    cycle(0, 0, 0, 1, d, a0, a1, a2);
  endtask

  task automatic idle(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    cycle(0, 0, 0, 0, 32'h0, a0, a1, a2);
  endtask

  initial begin
    rst = 1; start = 0; done = 0; vld = 0; rdata = '0; ab = '0; ag = '0; ar = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = 8'hxx;
    m_loading = 0; m_full = 0; m_ovf = 0; m_cnt = 0;

    // Reset state with in-range, last and out-of-range addresses
    cycle(1, 0, 0, 0, 32'h0, 8'd0, 8'd63, 8'd64);
    cycle(1, 0, 0, 0, 32'h0, 8'd0, 8'd63, 8'd64);
    idle(8'd0, 8'd63, 8'd64);
    chk("rst_pix_b", 32'(pb), 32'h00);
    chk("rst_pix_r_oor", 32'(pr), 32'h00);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);

    // Full tile fill, back-to-back
    cycle(0, 1, 0, 0, 32'h0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 16; k++) word(32'h03020100 + k * 32'h04040404, 8'd0, 8'd0, 8'd0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_cnt", 32'(cnt), 32'd16);
    idle(8'h00, 8'h05, 8'h3F);
    chk("fill_b0", 32'(pb), 32'h03);
    chk("fill_g5", 32'(pg), 32'h06);
    chk("fill_r63", 32'(pr), 32'h3C);

    // Overflow in FULL: word dropped, OVF set; START clears it
    word(32'hFFFFFFFF, 8'd0, 8'd0, 8'd0);
    chk("ovf_b0_kept", 32'(pb), 32'h03);
    chk("ovf_set", 32'(ovf), 32'd1);
    cycle(0, 1, 0, 0, 32'h0, 8'd0, 8'd0, 8'd0);
    chk("ovf_clr", 32'(ovf), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    // Bypass at word index 2
    word(32'h10203040, 8'd0, 8'd0, 8'd0);
    word(32'h50607080, 8'd0, 8'd0, 8'd0);
    word(32'hAABBCCDD, 8'd8, 8'd9, 8'd11);
    chk("byp_b", 32'(pb), 32'hAA);
    chk("byp_g", 32'(pg), 32'hBB);
    chk("byp_r", 32'(pr), 32'hDD);

    // Abort and restart in the same cycle after 5 words
    word(32'h0badf00d, 8'd0, 8'd0, 8'd0);
    word(32'hdeadbeef, 8'd0, 8'd0, 8'd0);
    cycle(0, 1, 1, 0, 32'h0, 8'd0, 8'd0, 8'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_cnt", 32'(cnt), 32'd0);
    word(32'h11223344, 8'd0, 8'd1, 8'd3);
    chk("restart_b0", 32'(pb), 32'h11);
    chk("restart_r3", 32'(pr), 32'h44);

    // Mid-fill reset after 8 words
    for (int k = 1; k < 8; k++) word(32'h01010101 * k, 8'd4, 8'd4, 8'd4);
    cycle(1, 0, 0, 0, 32'h0, 8'd4, 8'd4, 8'd4);
    idle(8'd4, 8'd4, 8'd4);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cnt", 32'(cnt), 32'd0);
    chk("mrst_pix4", 32'(pb), 32'h00);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0), $urandom(),
            8'($urandom_range(0, 79)), 8'($urandom_range(0, 79)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
